// File: rtl/adc_spi_reader.sv
// SPI read-frame engine for an ADC128S022-style converter: each rising edge of
// sample_clk runs one FRAME_BITS-long frame and returns the last DATA_WIDTH bits.
module adc_spi_reader #(
  parameter int unsigned SCLK_DIV   = 25,
  parameter int unsigned FRAME_BITS = 16,
  parameter int unsigned DATA_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sample_clk,
  input  logic [2:0]            channel,
  input  logic                  adc_dout,
  output logic                  adc_cs_n,
  output logic                  adc_sclk,
  output logic                  adc_din,
  output logic [DATA_WIDTH-1:0] sample_data,
  output logic [2:0]            sample_ch,
  output logic                  sample_valid,
  output logic                  busy,
  output logic                  overrun
);

  localparam int unsigned HC_W  = $clog2(SCLK_DIV);
  localparam int unsigned BIT_W = $clog2(FRAME_BITS);
  localparam logic [HC_W-1:0]  HC_LAST  = HC_W'(SCLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t                  state, state_n;
  logic [HC_W-1:0]         hc, hc_n;
  logic [BIT_W-1:0]        bit_cnt, bit_cnt_n;
  logic [FRAME_BITS-1:0]   cmd_sr, cmd_sr_n, cmd_new;
  logic [FRAME_BITS-1:0]   shift_in, shift_in_n;
  logic [2:0]              ch_lat, ch_lat_n;
  logic                    sample_clk_q;
  logic                    start;
  logic                    cs_n_n, sclk_n, din_n, valid_n, overrun_n;
  logic [DATA_WIDTH-1:0]   data_n;
  logic [2:0]              sch_n;

  assign start = sample_clk & ~sample_clk_q;
  assign busy  = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      hc           <= '0;
      bit_cnt      <= '0;
      cmd_sr       <= '0;
      shift_in     <= '0;
      ch_lat       <= '0;
      sample_clk_q <= 1'b1;
      adc_cs_n     <= 1'b1;
      adc_sclk     <= 1'b1;
      adc_din      <= 1'b0;
      sample_data  <= '0;
      sample_ch    <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      state        <= state_n;
      hc           <= hc_n;
      bit_cnt      <= bit_cnt_n;
      cmd_sr       <= cmd_sr_n;
      shift_in     <= shift_in_n;
      ch_lat       <= ch_lat_n;
      sample_clk_q <= sample_clk;
      adc_cs_n     <= cs_n_n;
      adc_sclk     <= sclk_n;
      adc_din      <= din_n;
      sample_data  <= data_n;
      sample_ch    <= sch_n;
      sample_valid <= valid_n;
      overrun      <= overrun_n;
    end
  end

  always_comb begin
    state_n    = state;
    hc_n       = hc;
    bit_cnt_n  = bit_cnt;
    cmd_sr_n   = cmd_sr;
    shift_in_n = shift_in;
    ch_lat_n   = ch_lat;
    cs_n_n     = adc_cs_n;
    sclk_n     = adc_sclk;
    din_n      = adc_din;
    data_n     = sample_data;
    sch_n      = sample_ch;
    valid_n    = 1'b0;
    overrun_n  = start && (state != IDLE);
    cmd_new    = '0;
    cmd_new[FRAME_BITS-3 -: 3] = channel;

    unique case (state)
      IDLE: begin
        if (start) begin
          state_n  = SETUP;
          ch_lat_n = channel;
          cmd_sr_n = cmd_new;
          hc_n     = '0;
          cs_n_n   = 1'b0;
          sclk_n   = 1'b1;
          din_n    = cmd_new[FRAME_BITS-1];
        end
      end
      SETUP: begin
        if (hc == HC_LAST) begin
          state_n   = SHIFT;
          hc_n      = '0;
          bit_cnt_n = '0;
          sclk_n    = 1'b0;
          din_n     = cmd_sr[FRAME_BITS-1];
          cmd_sr_n  = cmd_sr << 1;
        end else begin
          hc_n = hc + 1'b1;
        end
      end
      SHIFT: begin
        // adc_sclk doubles as the half-bit phase: low = first half, high = second
        if (hc == HC_LAST) begin
          hc_n = '0;
          if (!adc_sclk) begin
            sclk_n     = 1'b1;
            shift_in_n = {shift_in[FRAME_BITS-2:0], adc_dout};
          end else if (bit_cnt == BIT_LAST) begin
            state_n   = HOLD;
            bit_cnt_n = '0;
            cs_n_n    = 1'b1;
            din_n     = 1'b0;
            valid_n   = 1'b1;
            data_n    = shift_in[DATA_WIDTH-1:0];
            sch_n     = ch_lat;
          end else begin
            bit_cnt_n = bit_cnt + 1'b1;
            sclk_n    = 1'b0;
            din_n     = cmd_sr[FRAME_BITS-1];
            cmd_sr_n  = cmd_sr << 1;
          end
        end else begin
          hc_n = hc + 1'b1;
        end
      end
      HOLD: begin
        if (hc == HC_LAST) begin
          state_n = IDLE;
          hc_n    = '0;
        end else begin
          hc_n = hc + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_adc_spi_reader.sv
// Scoreboard bench for adc_spi_reader: default build plus a SCLK_DIV=2 build,
// each driven against a behavioural serial ADC.
module tb_adc_spi_reader;

  typedef struct {
    logic [11:0] data;
    logic [2:0]  ch;
    int          t0;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_clk = 1'b1;
  logic        sample_clk2 = 1'b0;
  logic [2:0]  channel = '0;
  logic        adc_dout = 1'b0, adc_dout2 = 1'b0;
  logic        cs_n, sclk, din, valid, busy, overrun;
  logic        cs_n2, sclk2, din2, valid2, busy2, overrun2;
  logic [11:0] data, data2;
  logic [2:0]  sch, sch2;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  exp_t q[$];
  exp_t q2[$];

  logic [15:0] adc_word = '0, adc_word2 = '0;
  logic [15:0] din_word = '0;
  int falls = 0, falls2 = 0;
  int last_edge = 0;
  logic sclk_bad = 1'b0;
  logic prev_sclk = 1'b1, prev_cs = 1'b1, prev_valid = 1'b0, prev_ov = 1'b0;
  logic prev_valid2 = 1'b0;
  int ov_seen = 0, ov_expected = 0;

  adc_spi_reader dut (
    .clk(clk), .rst(rst), .sample_clk(sample_clk), .channel(channel),
    .adc_dout(adc_dout), .adc_cs_n(cs_n), .adc_sclk(sclk), .adc_din(din),
    .sample_data(data), .sample_ch(sch), .sample_valid(valid),
    .busy(busy), .overrun(overrun)
  );

  adc_spi_reader #(.SCLK_DIV(2)) dut2 (
    .clk(clk), .rst(rst), .sample_clk(sample_clk2), .channel(channel),
    .adc_dout(adc_dout2), .adc_cs_n(cs_n2), .adc_sclk(sclk2), .adc_din(din2),
    .sample_data(data2), .sample_ch(sch2), .sample_valid(valid2),
    .busy(busy2), .overrun(overrun2)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ADC models: first bit appears on CS fall, each later bit on an SCLK fall
  always @(negedge cs_n) begin
    falls = 0; adc_dout = adc_word[15]; din_word = '0;
  end
  always @(negedge sclk) if (cs_n === 1'b0) begin
    if (falls < 16) adc_dout = adc_word[15-falls];
    falls++;
  end
  always @(posedge sclk) if (cs_n === 1'b0) din_word = {din_word[14:0], din};

  always @(negedge cs_n2) begin
    falls2 = 0; adc_dout2 = adc_word2[15];
  end
  always @(negedge sclk2) if (cs_n2 === 1'b0) begin
    if (falls2 < 16) adc_dout2 = adc_word2[15-falls2];
    falls2++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (cs_n === 1'b0 && prev_cs === 1'b1) begin
      last_edge = cyc; sclk_bad = 1'b0;
    end else if (sclk !== prev_sclk || cs_n !== prev_cs) begin
      if (cyc - last_edge != 25) sclk_bad = 1'b1;
      last_edge = cyc;
    end
    if (valid === 1'b1) begin
      check("valid_width", {31'b0, prev_valid}, 0);
      if (q.size() == 0) check("unexpected_valid", 1, 0);
      else begin
        e = q.pop_front();
        check("sample_data", {20'b0, data}, {20'b0, e.data});
        check("sample_ch", {29'b0, sch}, {29'b0, e.ch});
        check("valid_latency", cyc - e.t0, e.lat);
        check("sclk_falls", falls, 16);
        check("din_cmd", {16'b0, din_word}, {16'b0, 2'b00, e.ch, 11'b0});
        check("sclk_half_period", {31'b0, sclk_bad}, 0);
      end
    end
    if (overrun === 1'b1) begin
      check("overrun_width", {31'b0, prev_ov}, 0);
      ov_seen++;
    end
    if (valid2 === 1'b1) begin
      check("valid2_width", {31'b0, prev_valid2}, 0);
      if (q2.size() == 0) check("unexpected_valid2", 1, 0);
      else begin
        e = q2.pop_front();
        check("sample_data2", {20'b0, data2}, {20'b0, e.data});
        check("sample_ch2", {29'b0, sch2}, {29'b0, e.ch});
        check("valid2_latency", cyc - e.t0, e.lat);
        check("sclk2_falls", falls2, 16);
      end
    end
    prev_sclk = sclk; prev_cs = cs_n; prev_valid = valid;
    prev_ov = overrun; prev_valid2 = valid2;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start1(input logic [2:0] ch, input logic [15:0] word);
    @(posedge clk); #1;
    adc_word = word;
    channel  = ch;
    q.push_back('{word[11:0], ch, cyc, 826});
    sample_clk = 1'b1;
  endtask

  task automatic start2(input logic [2:0] ch, input logic [15:0] word);
    @(posedge clk); #1;
    adc_word2 = word;
    channel   = ch;
    q2.push_back('{word[11:0], ch, cyc, 67});
    sample_clk2 = 1'b1;
  endtask

  logic [15:0] words[4] = '{16'h0000, 16'h0FFF, 16'h0800, 16'h0001};

  initial begin
    // reset with sample_clk already high: no frame on release
    wait_cycles(3);
    check("rst_cs_n", {31'b0, cs_n}, 1);
    check("rst_sclk", {31'b0, sclk}, 1);
    check("rst_din", {31'b0, din}, 0);
    check("rst_data", {20'b0, data}, 0);
    check("rst_ch", {29'b0, sch}, 0);
    check("rst_valid", {31'b0, valid}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_overrun", {31'b0, overrun}, 0);
    rst = 1'b0;
    wait_cycles(100);
    check("release_cs_n", {31'b0, cs_n}, 1);
    check("release_busy", {31'b0, busy}, 0);
    sample_clk = 1'b0;
    wait_cycles(10);

    // basic frame, channel changed mid-frame must not matter
    start1(3'd5, 16'h0A5C);
    wait_cycles(5);
    channel = 3'd2;
    wait_cycles(900);
    sample_clk = 1'b0;
    wait_cycles(10);

    // four frames at the 8000-cycle sample period
    for (int i = 0; i < 4; i++) begin
      start1(3'(i), words[i]);
      wait_cycles(3999);
      sample_clk = 1'b0;
      wait_cycles(3999);
    end

    // second request mid-frame: overrun, first frame unaffected
    start1(3'd7, 16'h0123);
    wait_cycles(200);
    sample_clk = 1'b0;
    wait_cycles(200);
    sample_clk = 1'b1;
    ov_expected++;
    wait_cycles(500);
    check("no_second_frame_busy", {31'b0, busy}, 0);
    check("no_second_frame_cs", {31'b0, cs_n}, 1);
    sample_clk = 1'b0;
    wait_cycles(10);

    // reset mid-frame aborts, then a clean frame
    start1(3'd1, 16'h0456);
    wait_cycles(299);
    rst = 1'b1;
    wait_cycles(1);
    check("abort_cs_n", {31'b0, cs_n}, 1);
    check("abort_sclk", {31'b0, sclk}, 1);
    check("abort_busy", {31'b0, busy}, 0);
    q.delete();
    rst = 1'b0;
    sample_clk = 1'b0;
    wait_cycles(50);
    start1(3'd6, 16'h0789);
    wait_cycles(900);
    sample_clk = 1'b0;

    // SCLK_DIV=2 build
    start2(3'd4, 16'h03C3);
    wait_cycles(100);
    sample_clk2 = 1'b0;
    wait_cycles(10);

    check("queue_drained", q.size(), 0);
    check("queue2_drained", q2.size(), 0);
    check("overrun_count", ov_seen, ov_expected);
    check("final_busy", {31'b0, busy}, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
